avalon_burst_slave_mem: RTL and testbench

//  Avalon-MM burst slave with an on-chip word buffer; terminates the transactions produced by the

---
 rtl/avalon_burst_slave_mem.sv | 175 +++++++++++++++++
 tb/tb_avalon_burst_slave_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_slave_mem.sv
// Avalon-MM burst slave backed by an on-chip word buffer.
// One burst at a time; reads return through a two-stage (RAM + output) register pipeline.
module avalon_burst_slave_mem #(
    parameter int DATA_W  = 1024,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 11,
    parameter int DEPTH   = 64
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [BURST_W-1:0]    burstcount,
    input  logic                  beginbursttransfer,
    output logic [DATA_W-1:0]     readdata,
    output logic                  waitrequest,
    output logic                  readdatavalid,
    output logic                  wr_done,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int AW   = $clog2(DEPTH);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       base_q;
    logic [BURST_W-1:0]  total_q;
    logic [BURST_W-1:0]  beat_q;
    logic                waitreq_q;
    logic                ramValid_q;
    logic                rdValid_q;
    logic [DATA_W-1:0]   readdata_q;
    logic [DATA_W-1:0]   ramData_q;
    logic                wrDone_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept_d;
    logic [BURST_W-1:0]  burstN_d;
    logic                lastBeat_d;
    logic                wrBeat_d;
    logic [AW-1:0]       wrIdx_d;
    logic                rdIssue_d;
    logic [AW-1:0]       rdIdx_d;
    logic                errEvent_d;
    logic                unused_inputs;

    // beginbursttransfer is informational and address bits above AW are don't-care.
    assign unused_inputs = ^{beginbursttransfer, address[ADDR_W-1:AW]};

    always_comb begin
        accept_d   = (state_q == IDLE) && chipselect && (read || write) && !waitreq_q;
        burstN_d   = (burstcount == '0) ? BURST_W'(1) : burstcount;
        lastBeat_d = (beat_q == (total_q - BURST_W'(1)));
        wrBeat_d   = 1'b0;
        wrIdx_d    = base_q + beat_q[AW-1:0];
        rdIssue_d  = (state_q == RD_ISSUE);
        rdIdx_d    = base_q + beat_q[AW-1:0];
        errEvent_d = 1'b0;
        case (state_q)
            IDLE: begin
                wrBeat_d   = accept_d && write;
                wrIdx_d    = address[AW-1:0];
                errEvent_d = accept_d && ((burstcount == '0) || (read && write));
            end
            WR: begin
                wrBeat_d   = chipselect && write;
                errEvent_d = chipselect && read;
            end
            default: ;
        endcase
    end

    // Buffer storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wrBeat_d) begin
            for (int b = 0; b < BE_W; b++) begin
                if (byteenable[b]) begin
                    mem[wrIdx_d][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
        if (rdIssue_d) begin
            ramData_q <= mem[rdIdx_d];
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            total_q    <= '0;
            beat_q     <= '0;
            waitreq_q  <= 1'b1;
            ramValid_q <= 1'b0;
            rdValid_q  <= 1'b0;
            readdata_q <= '0;
            wrDone_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wrDone_q   <= 1'b0;
            ramValid_q <= rdIssue_d;
            rdValid_q  <= ramValid_q;
            if (ramValid_q) begin
                readdata_q <= ramData_q;
            end
            err_q <= (err_q && !err_clr) || errEvent_d;

            case (state_q)
                IDLE: begin
                    waitreq_q <= 1'b0;
                    if (accept_d) begin
                        base_q  <= address[AW-1:0];
                        total_q <= burstN_d;
                        if (write) begin
                            beat_q <= BURST_W'(1);
                            if (burstN_d == BURST_W'(1)) begin
                                wrDone_q <= 1'b1;
                            end else begin
                                state_q <= WR;
                            end
                        end else begin
                            beat_q    <= '0;
                            waitreq_q <= 1'b1;
                            state_q   <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (wrBeat_d) begin
                        beat_q <= beat_q + BURST_W'(1);
                        if (lastBeat_d) begin
                            wrDone_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                RD_ISSUE: begin
                    beat_q <= beat_q + BURST_W'(1);
                    if (lastBeat_d) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    // The RAM stage empties one cycle before the output stage's last beat.
                    if (!ramValid_q) begin
                        waitreq_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign readdata      = readdata_q;
    assign waitrequest   = waitreq_q;
    assign readdatavalid = rdValid_q;
    assign wr_done       = wrDone_q;
    assign err           = err_q;

endmodule

// File: tb/tb_avalon_burst_slave_mem.sv
// Directed bench for avalon_burst_slave_mem: bursts, wrap, byteenable, errors and mid-burst reset.
module tb_avalon_burst_slave_mem;

    localparam int DW = 1024;
    localparam int AWB = 32;
    localparam int BW = 11;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            arst;
    logic [AWB-1:0]  address;
    logic [DW/8-1:0] byteenable;
    logic            chipselect;
    logic            read;
    logic            write;
    logic [DW-1:0]   writedata;
    logic [BW-1:0]   burstcount;
    logic            beginbursttransfer;
    logic [DW-1:0]   readdata;
    logic            waitrequest;
    logic            readdatavalid;
    logic            wr_done;
    logic            err;
    logic            err_clr;

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model [DEPTH];

    avalon_burst_slave_mem #(
        .DATA_W(DW), .ADDR_W(AWB), .BURST_W(BW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .arst(arst), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .burstcount(burstcount), .beginbursttransfer(beginbursttransfer),
        .readdata(readdata), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
        .wr_done(wr_done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed %h expected %h (low 64 bits)", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {(DW/8){b}};
    endfunction

    // Bounded wait for the slave to be ready for a new command.
    task automatic waitIdle();
        int i = 0;
        while (waitrequest !== 1'b0 && i < 20) begin
            tick();
            i++;
        end
        checkOutput("idle_wait", {1023'b0, waitrequest}, '0);
    endtask

    task automatic applyStimulus(input logic [AWB-1:0] addr, input int n, input logic [BW-1:0] bc,
                                 input logic [7:0] dataBase, input logic [DW/8-1:0] be,
                                 input int gap, input logic alsoRead);
        logic [5:0] idx;
        logic [DW-1:0] d;
        waitIdle();
        for (int k = 0; k < n; k++) begin
            d = fill(dataBase + 8'(k));
            chipselect = 1'b1;
            write      = 1'b1;
            writedata  = d;
            byteenable = be;
            if (k == 0) begin
                address            = addr;
                burstcount         = bc;
                beginbursttransfer = 1'b1;
                read               = alsoRead;
            end
            idx = addr[5:0] + 6'(k);
            for (int b = 0; b < DW/8; b++) begin
                if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            end
            tick();
            read = 1'b0;
            beginbursttransfer = 1'b0;
            write = 1'b0;
            checkOutput("wr_done_beat", {1023'b0, wr_done}, {1023'b0, (k == n-1)});
            if (k < n-1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    checkOutput("wr_done_gap", {1023'b0, wr_done}, '0);
                end
            end
        end
        chipselect = 1'b0;
        tick();
        checkOutput("wr_done_pulse_end", {1023'b0, wr_done}, '0);
    endtask

    task automatic readBurst(input logic [AWB-1:0] addr, input int n, input logic [BW-1:0] bc,
                             input logic clr);
        int idx;
        waitIdle();
        chipselect = 1'b1;
        read       = 1'b1;
        address    = addr;
        burstcount = bc;
        err_clr    = clr;
        beginbursttransfer = 1'b1;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        err_clr    = 1'b0;
        beginbursttransfer = 1'b0;
        for (int c = 1; c <= n + 2; c++) begin
            checkOutput("rd_waitreq_busy", {1023'b0, waitrequest}, {1023'b0, 1'b1});
            checkOutput("rd_valid", {1023'b0, readdatavalid}, {1023'b0, (c >= 3)});
            if (c >= 3) begin
                idx = (int'(addr[5:0]) + c - 3) % DEPTH;
                checkOutput("rd_data", readdata, model[idx]);
            end
            tick();
        end
        checkOutput("rd_waitreq_done", {1023'b0, waitrequest}, '0);
        checkOutput("rd_valid_done", {1023'b0, readdatavalid}, '0);
    endtask

    initial begin
        arst = 1'b0;
        address = '0; byteenable = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; burstcount = '0; beginbursttransfer = 1'b0; err_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_waitreq", {1023'b0, waitrequest}, {1023'b0, 1'b1});
        checkOutput("rst_rdvalid", {1023'b0, readdatavalid}, '0);
        checkOutput("rst_readdata", readdata, '0);
        checkOutput("rst_wr_done", {1023'b0, wr_done}, '0);
        checkOutput("rst_err", {1023'b0, err}, '0);
        @(negedge clk);
        arst = 1'b1;
        tick();
        checkOutput("rel_waitreq", {1023'b0, waitrequest}, '0);

        // Single-beat write then read at word 3.
        applyStimulus(32'd3, 1, 11'd1, 8'hA5, '1, 0, 1'b0);
        readBurst(32'd3, 1, 11'd1, 1'b0);
        checkOutput("a5_readback", readdata, fill(8'hA5));

        // Four beats with two idle cycles between each.
        applyStimulus(32'd5, 4, 11'd4, 8'h10, '1, 2, 1'b0);
        readBurst(32'd5, 4, 11'd4, 1'b0);
        checkOutput("gap_last_beat", readdata, fill(8'h13));

        // Burst crossing the top of the buffer.
        applyStimulus(32'd62, 4, 11'd4, 8'h20, '1, 0, 1'b0);
        readBurst(32'd62, 4, 11'd4, 1'b0);
        readBurst(32'd0, 2, 11'd2, 1'b0);
        checkOutput("wrap_word1", readdata, fill(8'h23));

        // Byteenable: only byte 0 overwritten.
        applyStimulus(32'd10, 1, 11'd1, 8'hFF, '1, 0, 1'b0);
        applyStimulus(32'd10, 1, 11'd1, 8'h00, {{(DW/8-1){1'b0}}, 1'b1}, 0, 1'b0);
        readBurst(32'd10, 1, 11'd1, 1'b0);
        checkOutput("be_readback", readdata, {{(DW/8-1){8'hFF}}, 8'h00});

        // Zero burstcount behaves as one beat and flags an error.
        checkOutput("err_clean", {1023'b0, err}, '0);
        readBurst(32'd3, 1, 11'd0, 1'b0);
        checkOutput("err_bc0", {1023'b0, err}, {1023'b0, 1'b1});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_cleared", {1023'b0, err}, '0);

        // Read and write together: write wins.
        applyStimulus(32'd7, 1, 11'd1, 8'h5C, '1, 0, 1'b1);
        checkOutput("err_rw", {1023'b0, err}, {1023'b0, 1'b1});
        readBurst(32'd7, 1, 11'd1, 1'b0);
        checkOutput("rw_write_won", readdata, fill(8'h5C));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("err_cleared2", {1023'b0, err}, '0);

        // Set and clear in the same cycle leaves err set.
        readBurst(32'd3, 1, 11'd0, 1'b1);
        checkOutput("err_set_beats_clr", {1023'b0, err}, {1023'b0, 1'b1});
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Upper address bits are ignored.
        readBurst(32'hFFFF_FFC3, 1, 11'd1, 1'b0);
        checkOutput("upper_addr", readdata, fill(8'hA5));

        // Reset in the middle of an 8-beat read.
        waitIdle();
        chipselect = 1'b1; read = 1'b1; address = 32'd0; burstcount = 11'd8;
        tick();
        chipselect = 1'b0; read = 1'b0;
        tick();
        tick();
        checkOutput("mid_beat1", {1023'b0, readdatavalid}, {1023'b0, 1'b1});
        tick();
        checkOutput("mid_beat2", {1023'b0, readdatavalid}, {1023'b0, 1'b1});
        #2;
        arst = 1'b0;
        #1;
        checkOutput("mid_rst_rdvalid", {1023'b0, readdatavalid}, '0);
        checkOutput("mid_rst_waitreq", {1023'b0, waitrequest}, {1023'b0, 1'b1});
        checkOutput("mid_rst_readdata", readdata, '0);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        tick();
        checkOutput("mid_rel_waitreq", {1023'b0, waitrequest}, '0);
        tick();
        checkOutput("mid_rel_rdvalid", {1023'b0, readdatavalid}, '0);
        readBurst(32'd3, 1, 11'd1, 1'b0);
        checkOutput("post_rst_read", readdata, fill(8'hA5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
